// File: rtl/fc_rx_frame_check.sv
// rtl/fc_rx_frame_check.sv - FC RX frame checker: strips SOF/EOF/CRC, checks CRC-32 and length, keeps stats
//
// fc_crc32_word: one 32-bit word step of the FC CRC-32, bytes [31:24] first, each byte LSB first.
//   crc_in   running CRC register (non-reflected form)
//   data     word to fold in
//   crc_out  updated CRC register
//
// fc_rx_frame_check ports:
//   clk, reset_n                         rx_clk domain clock, asynchronous active-low reset
//   in_data, in_valid                    framed words from the framer user RX (no backpressure)
//   in_startofpacket, in_endofpacket     word is the SOF / EOF primitive
//   out_data, out_valid                  header+payload words (downstream always accepts)
//   out_startofpacket, out_endofpacket   first header word / last payload word of a frame
//   out_error                            frame bad, qualified by out_endofpacket
//   mm_address, mm_read, mm_readdata     statistics read port, registered 1-cycle read data

module fc_crc32_word (
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic [31:0] c;
  logic        fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int b = 3; b >= 0; b--) begin
      for (int i = 0; i < 8; i++) begin
        // Each byte enters LSB first: the bit reflection lives in the feed order.
        fb = c[31] ^ data[8*b + i];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    crc_out = c;
  end

endmodule

module fc_rx_frame_check #(
  parameter int MAX_WORDS = 535,
  parameter int MIN_WORDS = 7,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic        out_error,
  input  logic [2:0]  mm_address,
  input  logic        mm_read,
  output logic [31:0] mm_readdata
);

  localparam int CW = $clog2(MAX_WORDS + 2);

  localparam logic [CW-1:0]    C_ONE   = CW'(1);
  localparam logic [CW-1:0]    C_TWO   = CW'(2);
  localparam logic [CW-1:0]    C_MIN   = CW'(MIN_WORDS);
  localparam logic [CW-1:0]    C_MAX   = CW'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    DISCARD
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     count;
  logic [31:0]       crc;
  logic [31:0]       crc_next;
  logic [31:0]       crc_refl;
  logic              crc_ok;
  logic [31:0]       h0;
  logic [31:0]       h1;
  logic              first_pend;

  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  crc_err_cnt;
  logic [CNT_W-1:0]  len_err_cnt;
  logic [CNT_W-1:0]  abort_cnt;

  logic              start;
  logic              shift;
  logic              bump;
  logic              emit;
  logic              emit_eop;
  logic              emit_err;
  logic              inc_good;
  logic              inc_crc;
  logic              inc_len;
  logic              inc_abort;
  logic              h0_full;
  logic              h1_full;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // CRC only ever covers words that have moved from h0 into h1, so at EOF
  // it spans every data word except the trailing CRC word still in h0.
  fc_crc32_word u_crc (
    .crc_in  (crc),
    .data    (h0),
    .crc_out (crc_next)
  );

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      crc_refl[i] = ~crc[31-i];
    end
    crc_ok = (crc_refl == h0);
  end

  // The holds fill strictly in order after SOF, so the word count tells
  // how many of them carry frame data.
  assign h0_full = (count >= C_ONE);
  assign h1_full = (count >= C_TWO);

  always_comb begin
    next_state = state;
    start      = 1'b0;
    shift      = 1'b0;
    bump       = 1'b0;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    emit_err   = 1'b0;
    inc_good   = 1'b0;
    inc_crc    = 1'b0;
    inc_len    = 1'b0;
    inc_abort  = 1'b0;
    if (in_valid) begin
      if (in_startofpacket) begin
        // SOF always opens a new frame; inside a frame it also aborts the old one.
        start      = 1'b1;
        next_state = IN_FRAME;
        if (state == IN_FRAME) begin
          inc_abort = 1'b1;
          if (h1_full) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = 1'b1;
          end
        end
      end else begin
        unique case (state)
          IN_FRAME: begin
            if (in_endofpacket) begin
              next_state = IDLE;
              if (h1_full) begin
                emit     = 1'b1;
                emit_eop = 1'b1;
                if (count < C_MIN) begin
                  emit_err = 1'b1;
                  inc_len  = 1'b1;
                end else if (!crc_ok) begin
                  emit_err = 1'b1;
                  inc_crc  = 1'b1;
                end else begin
                  inc_good = 1'b1;
                end
              end else begin
                inc_len = 1'b1;
              end
            end else if (count == C_MAX) begin
              next_state = DISCARD;
              bump       = 1'b1;
              inc_len    = 1'b1;
              if (h1_full) begin
                emit     = 1'b1;
                emit_eop = 1'b1;
                emit_err = 1'b1;
              end
            end else begin
              shift = 1'b1;
              bump  = 1'b1;
              emit  = h1_full;
            end
          end
          DISCARD: begin
            if (in_endofpacket) begin
              next_state = IDLE;
            end
          end
          default: begin
            next_state = state;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      count             <= '0;
      crc               <= 32'hFFFF_FFFF;
      h0                <= '0;
      h1                <= '0;
      first_pend        <= 1'b0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      good_cnt          <= '0;
      crc_err_cnt       <= '0;
      len_err_cnt       <= '0;
      abort_cnt         <= '0;
    end else begin
      state             <= next_state;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;

      if (emit) begin
        out_data          <= h1;
        out_valid         <= 1'b1;
        out_startofpacket <= first_pend;
        out_endofpacket   <= emit_eop;
        out_error         <= emit_err;
        first_pend        <= 1'b0;
      end

      if (bump && (count <= C_MAX)) begin
        count <= count + C_ONE;
      end

      if (shift) begin
        h1 <= h0;
        h0 <= in_data;
        if (h0_full) begin
          crc <= crc_next;
        end
      end

      // Placed after the emit branch so a SOF that aborts a frame still
      // marks the next emitted word as start of packet.
      if (start) begin
        count      <= '0;
        crc        <= 32'hFFFF_FFFF;
        h0         <= '0;
        h1         <= '0;
        first_pend <= 1'b1;
      end

      if (inc_good)  good_cnt    <= sat_inc(good_cnt);
      if (inc_crc)   crc_err_cnt <= sat_inc(crc_err_cnt);
      if (inc_len)   len_err_cnt <= sat_inc(len_err_cnt);
      if (inc_abort) abort_cnt   <= sat_inc(abort_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm_readdata <= '0;
    end else if (mm_read) begin
      unique case (mm_address)
        3'd0:    mm_readdata <= 32'(good_cnt);
        3'd1:    mm_readdata <= 32'(crc_err_cnt);
        3'd2:    mm_readdata <= 32'(len_err_cnt);
        3'd3:    mm_readdata <= 32'(abort_cnt);
        3'd4:    mm_readdata <= 32'(count);
        default: mm_readdata <= 32'hFFFF_FFFF;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_rx_frame_check.sv
// tb/tb_fc_rx_frame_check.sv - self-checking bench for fc_rx_frame_check
//
// Drives framed words on the negative clock edge, captures every output beat
// on the negative edge, and compares against beats and counters built from
// the words the bench itself sent and its own CRC-32 model.

module tb_fc_rx_frame_check;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic        out_error;
  logic [2:0]  mm_address;
  logic        mm_read;
  logic [31:0] mm_readdata;

  always #5 clk = ~clk;

  fc_rx_frame_check dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_error         (out_error),
    .mm_address        (mm_address),
    .mm_read           (mm_read),
    .mm_readdata       (mm_readdata)
  );

  localparam logic [31:0] SOF_W = 32'hBCB5_5656;
  localparam logic [31:0] EOF_W = 32'hBC95_7575;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  typedef struct {
    int          n;
    bit          with_crc;
    logic [31:0] flip;
    int          nout;
    bit          err;
    int          dg;
    int          dc;
    int          dl;
  } vec_t;

  beat_t       rx_q[$];
  beat_t       exp_q[$];
  logic [31:0] tx[$];
  int          total = 0;
  int          bad   = 0;
  int          exp_good  = 0;
  int          exp_crc   = 0;
  int          exp_len   = 0;
  int          exp_abort = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      rx_q.push_back({out_data, out_startofpacket, out_endofpacket, out_endofpacket & out_error});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input int first, input int cnt);
    logic [31:0] r;
    logic [31:0] w;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      w = tx[first + i];
      for (int b = 3; b >= 0; b--) begin
        r = r ^ {24'h0, w[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
      end
    end
    return ~r;
  endfunction

  function automatic logic [31:0] word_of(input int i);
    if (i < 6) return 32'h1111_1111 * 32'(i + 1);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  task automatic add_frame(input int n, input bit with_crc, input logic [31:0] flip);
    int base;
    int nd;
    base = tx.size();
    nd   = with_crc ? n - 1 : n;
    for (int i = 0; i < nd; i++) tx.push_back(word_of(i));
    if (with_crc) tx.push_back(crc_model(base, nd) ^ flip);
  endtask

  task automatic put(input logic [31:0] d, input logic s, input logic e);
    in_data          = d;
    in_valid         = 1'b1;
    in_startofpacket = s;
    in_endofpacket   = e;
    @(negedge clk);
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int base, input int n, input bit gaps);
    put(SOF_W, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      put(tx[base + i], 1'b0, 1'b0);
      if (gaps) idle((i % 3) + 1);
    end
    put(EOF_W, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic expect_frame(input int base, input int nout, input bit err);
    for (int i = 0; i < nout; i++) begin
      exp_q.push_back({tx[base + i], (i == 0), (i == nout - 1), (i == nout - 1) && err});
    end
  endtask

  task automatic check_beats(input string name);
    int n;
    cmp({name, " beat count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      cmp($sformatf("%s beat %0d", name, i), 64'(rx_q[i]), 64'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic mm_rd(input logic [2:0] a, output logic [31:0] v);
    mm_address = a;
    mm_read    = 1'b1;
    @(negedge clk);
    mm_read    = 1'b0;
    v          = mm_readdata;
  endtask

  task automatic check_cnts(input string name);
    logic [31:0] v;
    mm_rd(3'd0, v); cmp({name, " good_cnt"}, 64'(v), 64'(exp_good));
    mm_rd(3'd1, v); cmp({name, " crc_err_cnt"}, 64'(v), 64'(exp_crc));
    mm_rd(3'd2, v); cmp({name, " len_err_cnt"}, 64'(v), 64'(exp_len));
    mm_rd(3'd3, v); cmp({name, " abort_cnt"}, 64'(v), 64'(exp_abort));
  endtask

  initial begin
    vec_t        tbl[8];
    logic [31:0] v;
    int          neop;

    // n data words incl. CRC, CRC present, CRC flip mask, beats out, eop error, d_good, d_crc, d_len
    tbl[0] = '{11, 1'b1, 32'h0,         10, 1'b0, 1, 0, 0};
    tbl[1] = '{11, 1'b1, 32'h1,         10, 1'b1, 0, 1, 0};
    tbl[2] = '{3,  1'b0, 32'h0,         2,  1'b1, 0, 0, 1};
    tbl[3] = '{1,  1'b0, 32'h0,         0,  1'b0, 0, 0, 1};
    tbl[4] = '{7,  1'b1, 32'h0,         6,  1'b0, 1, 0, 0};
    tbl[5] = '{6,  1'b1, 32'h1,         5,  1'b1, 0, 0, 1};
    tbl[6] = '{2,  1'b0, 32'h0,         1,  1'b1, 0, 0, 1};
    tbl[7] = '{8,  1'b1, 32'h8000_0000, 7,  1'b1, 0, 1, 0};

    reset_n          = 1'b0;
    in_data          = '0;
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    mm_address       = '0;
    mm_read          = 1'b0;
    idle(2);

    cmp("reset out_valid", 64'(out_valid), 64'(0));
    cmp("reset out_data", 64'(out_data), 64'(0));
    cmp("reset sop/eop/err", 64'({out_startofpacket, out_endofpacket, out_error}), 64'(0));
    cmp("reset mm_readdata", 64'(mm_readdata), 64'(0));

    reset_n = 1'b1;
    idle(2);
    check_cnts("after reset");
    mm_rd(3'd4, v); cmp("after reset frame count", 64'(v), 64'(0));
    for (int a = 5; a < 8; a++) begin
      mm_rd(3'(a), v);
      cmp($sformatf("unmapped addr %0d", a), 64'(v), 64'(32'hFFFF_FFFF));
    end
    idle(1);
    cmp("mm_readdata hold", 64'(mm_readdata), 64'(32'hFFFF_FFFF));

    // Words outside a frame are dropped silently.
    put(32'hDEAD_BEEF, 1'b0, 1'b0);
    put(EOF_W, 1'b0, 1'b1);
    idle(3);
    check_beats("idle discard");

    for (int t = 0; t < 8; t++) begin
      tx.delete();
      add_frame(tbl[t].n, tbl[t].with_crc, tbl[t].flip);
      send(0, tbl[t].n, 1'b0);
      expect_frame(0, tbl[t].nout, tbl[t].err);
      check_beats($sformatf("vec%0d", t));
      exp_good += tbl[t].dg;
      exp_crc  += tbl[t].dc;
      exp_len  += tbl[t].dl;
      check_cnts($sformatf("vec%0d", t));
    end

    // Largest legal frame passes clean.
    tx.delete();
    add_frame(535, 1'b1, 32'h0);
    send(0, 535, 1'b0);
    expect_frame(0, 534, 1'b0);
    check_beats("max frame");
    exp_good++;
    check_cnts("max frame");

    // Oversize: the 536th data word closes the frame with an error; the rest is dropped.
    tx.delete();
    add_frame(540, 1'b0, 32'h0);
    send(0, 540, 1'b0);
    expect_frame(0, 534, 1'b1);
    check_beats("oversize");
    exp_len++;
    check_cnts("oversize");
    mm_rd(3'd4, v); cmp("oversize saturated count", 64'(v), 64'(536));

    tx.delete();
    add_frame(11, 1'b1, 32'h0);
    send(0, 11, 1'b0);
    expect_frame(0, 10, 1'b0);
    check_beats("after oversize");
    exp_good++;
    check_cnts("after oversize");

    // Missing EOF: second SOF aborts the first frame, second frame is clean.
    tx.delete();
    add_frame(5, 1'b0, 32'h0);
    add_frame(7, 1'b1, 32'h0);
    put(SOF_W, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) put(tx[i], 1'b0, 1'b0);
    send(5, 7, 1'b0);
    expect_frame(0, 4, 1'b1);
    expect_frame(5, 6, 1'b0);
    check_beats("abort");
    exp_abort++;
    exp_good++;
    check_cnts("abort");

    // Idle gaps between words do not disturb a good frame.
    tx.delete();
    add_frame(11, 1'b1, 32'h0);
    send(0, 11, 1'b1);
    expect_frame(0, 10, 1'b0);
    check_beats("gaps");
    exp_good++;
    check_cnts("gaps");

    // Reset pulse mid-frame: output drops at once, no eop, everything cleared.
    tx.delete();
    add_frame(11, 1'b1, 32'h0);
    put(SOF_W, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) put(tx[i], 1'b0, 1'b0);
    mm_rd(3'd4, v); cmp("mid-frame count", 64'(v), 64'(3));
    put(tx[3], 1'b0, 1'b0);
    cmp("out_valid before reset pulse", 64'(out_valid), 64'(1));
    #1 reset_n = 1'b0;
    #1 cmp("out_valid during reset", 64'(out_valid), 64'(0));
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 4; i < 11; i++) put(tx[i], 1'b0, 1'b0);
    put(EOF_W, 1'b0, 1'b1);
    idle(3);
    neop = 0;
    foreach (rx_q[i]) if (rx_q[i].eop) neop++;
    cmp("reset frame eop count", 64'(neop), 64'(0));
    cmp("reset frame beat count", 64'(rx_q.size()), 64'(2));
    rx_q.delete();
    exp_good  = 0;
    exp_crc   = 0;
    exp_len   = 0;
    exp_abort = 0;
    check_cnts("after mid-frame reset");
    mm_rd(3'd4, v); cmp("after mid-frame reset count", 64'(v), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
